fetch_unit: RTL and testbench

Instruction fetch stage of the multicycle datapath. It owns the fetch address and runs a request/acknowledge handshake with instruction memory, which may take any number of cycles to answer. It captures each returned 19-bit instruction and its 12-bit address into an output holding stage with valid/ready flow control, and feeds the decode stage directly. It also accepts branch redirects from the execute stage at any time, including while a memory request is outstanding.

---
 rtl/fetch_pkg.sv | 6 +
 rtl/fetch_unit.sv | 85 ++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and fetch FSM state encoding.
package fetch_pkg;
   localparam int ADDR_W = 12;
   localparam int INSTR_W = 19;
   typedef enum logic [1:0] {IDLE, REQ, FULL, DROP} fetch_state_t;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with req/ack memory handshake, redirect handling and a valid/ready holding stage.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W = fetch_pkg::ADDR_W,
   parameter int INSTR_W = fetch_pkg::INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               ir_valid,
   output logic [INSTR_W-1:0] ir,
   output logic [ADDR_W-1:0]  ir_pc,
   input  logic               ir_ready
);
   fetch_state_t state, state_n;
   logic [ADDR_W-1:0] fetch_pc, fetch_pc_n, redir_pc, redir_pc_n, ir_pc_n;
   logic [INSTR_W-1:0] ir_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         fetch_pc <= RESET_PC;
         redir_pc <= '0;
         ir <= '0;
         ir_pc <= '0;
      end else begin
         state <= state_n;
         fetch_pc <= fetch_pc_n;
         redir_pc <= redir_pc_n;
         ir <= ir_n;
         ir_pc <= ir_pc_n;
      end
   end

   // A redirect during an outstanding request parks in DROP so the in-flight answer is swallowed.
   always_comb begin
      state_n = state;
      fetch_pc_n = fetch_pc;
      redir_pc_n = redir_pc;
      ir_n = ir;
      ir_pc_n = ir_pc;
      case (state)
         IDLE: begin
            state_n = REQ;
            fetch_pc_n = redirect ? redirect_pc : fetch_pc;
         end
         REQ: begin
            if (redirect && imem_ack) begin
               fetch_pc_n = redirect_pc;
            end else if (redirect) begin
               redir_pc_n = redirect_pc;
               state_n = DROP;
            end else if (imem_ack) begin
               ir_n = imem_rdata;
               ir_pc_n = fetch_pc;
               fetch_pc_n = fetch_pc + 1'b1;
               state_n = FULL;
            end
         end
         FULL: begin
            fetch_pc_n = redirect ? redirect_pc : fetch_pc;
            state_n = (redirect || ir_ready) ? REQ : FULL;
         end
         DROP: begin
            redir_pc_n = redirect ? redirect_pc : redir_pc;
            if (imem_ack) begin
               fetch_pc_n = redirect ? redirect_pc : redir_pc;
               state_n = REQ;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign imem_req = (state == REQ) || (state == DROP);
   assign ir_valid = (state == FULL);
   assign imem_addr = fetch_pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic checked against a transaction-level fetch model.
module tb_fetch_unit;
   logic clk = 0;
   logic rst, imem_ack, redirect, ir_ready;
   logic [18:0] imem_rdata;
   logic [11:0] redirect_pc;
   logic imem_req, ir_valid;
   logic [11:0] imem_addr, ir_pc;
   logic [18:0] ir;
   int checks = 0;
   int errors = 0;

   // Model: whether a request is in flight, whether its answer is doomed, and what decode holds.
   logic m_fresh, m_req, m_drop, m_valid;
   logic [11:0] m_addr, m_pend, m_irpc;
   logic [18:0] m_ir;

   wire [44:0] dut_v = {imem_req, imem_addr, ir_valid, ir, ir_pc};
   wire [44:0] mod_v = {m_req, m_addr, m_valid, m_ir, m_irpc};

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
      .redirect_pc(redirect_pc), .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc),
      .ir_ready(ir_ready)
   );

   task automatic model_update();
      if (rst) begin
         m_fresh = 1; m_req = 0; m_drop = 0; m_valid = 0;
         m_addr = 0; m_pend = 0; m_ir = 0; m_irpc = 0;
      end else if (m_fresh) begin
         m_fresh = 0; m_req = 1;
         if (redirect) m_addr = redirect_pc;
      end else if (m_valid) begin
         if (redirect || ir_ready) begin m_valid = 0; m_req = 1; end
         if (redirect) m_addr = redirect_pc;
      end else if (m_req && m_drop) begin
         if (redirect) m_pend = redirect_pc;
         if (imem_ack) begin m_addr = m_pend; m_drop = 0; end
      end else if (m_req) begin
         if (redirect && imem_ack) m_addr = redirect_pc;
         else if (redirect) begin m_pend = redirect_pc; m_drop = 1; end
         else if (imem_ack) begin
            m_ir = imem_rdata; m_irpc = m_addr; m_addr = m_addr + 12'd1;
            m_valid = 1; m_req = 0;
         end
      end
   endtask

   task automatic step(input logic r, input logic a, input logic [18:0] d,
                       input logic rd, input logic [11:0] rp, input logic rdy);
      rst = r; imem_ack = a; imem_rdata = d; redirect = rd; redirect_pc = rp; ir_ready = rdy;
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic test_reset();
      step(1, 1, 19'h55555, 0, 0, 0);
      step(1, 0, 0, 1, 12'h777, 0);
      checks++;
      if ({imem_req, ir_valid, imem_addr, ir, ir_pc} !== 45'd0) begin
         errors++;
         $display("FAIL reset: req=%b valid=%b addr=%h ir=%h ir_pc=%h, want all zero", imem_req, ir_valid, imem_addr, ir, ir_pc);
      end
   endtask

   task automatic test_first_fetch();
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 12'h000) begin
            errors++;
            $display("FAIL first_req%0d: req=%b addr=%h, want 1 000", i, imem_req, imem_addr);
         end
         step(0, i == 1, 19'h1ABCD, 0, 0, 1);
      end
      checks++;
      if (ir_valid !== 1'b1 || ir !== 19'h1ABCD || ir_pc !== 12'h000 || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL first_capture: valid=%b ir=%h ir_pc=%h req=%b, want 1 1abcd 000 0", ir_valid, ir, ir_pc, imem_req);
      end
      step(0, 0, 0, 0, 0, 1);
      checks++;
      if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 12'h001) begin
         errors++;
         $display("FAIL first_next: valid=%b req=%b addr=%h, want 0 1 001", ir_valid, imem_req, imem_addr);
      end
   endtask

   task automatic test_backpressure();
      logic [18:0] d;
      d = 19'($urandom);
      step(0, 1, d, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (ir_valid !== 1'b1 || ir !== d || ir_pc !== 12'h001 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL backpressure%0d: valid=%b ir=%h ir_pc=%h req=%b, want 1 %h 001 0", i, ir_valid, ir, ir_pc, imem_req, d);
         end
         step(0, 1, 19'h0, 0, 0, 0);
      end
      checks++;
      if (ir !== d || ir_valid !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_hold: ir=%h valid=%b, want %h 1", ir, ir_valid, d);
      end
      step(0, 0, 0, 0, 0, 1);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 12'h002 || ir_valid !== 1'b0) begin
         errors++;
         $display("FAIL backpressure_release: req=%b addr=%h valid=%b, want 1 002 0", imem_req, imem_addr, ir_valid);
      end
   endtask

   task automatic test_redirect_full();
      step(0, 1, 19'h2468A, 0, 0, 0);
      step(0, 0, 0, 1, 12'h200, 1);
      checks++;
      if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 12'h200 || ir !== 19'h2468A || ir_pc !== 12'h002) begin
         errors++;
         $display("FAIL redirect_full: valid=%b req=%b addr=%h ir=%h ir_pc=%h, want 0 1 200 2468a 002", ir_valid, imem_req, imem_addr, ir, ir_pc);
      end
   endtask

   task automatic test_redirect_outstanding();
      step(0, 1, 19'h11111, 1, 12'h005, 0);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 12'h005 || ir_valid !== 1'b0) begin
         errors++;
         $display("FAIL redirect_ack_to_005: req=%b addr=%h valid=%b, want 1 005 0", imem_req, imem_addr, ir_valid);
      end
      step(0, 0, 0, 1, 12'h300, 0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 12'h005 || ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_wait%0d: req=%b addr=%h valid=%b, want 1 005 0", i, imem_req, imem_addr, ir_valid);
         end
         step(0, i == 2, 19'h7FFFF, 0, 0, 1);
      end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 12'h300 || ir_valid !== 1'b0 || ir === 19'h7FFFF) begin
         errors++;
         $display("FAIL drop_done: req=%b addr=%h valid=%b ir=%h, want 1 300 0 not 7ffff", imem_req, imem_addr, ir_valid, ir);
      end
      step(0, 0, 0, 0, 0, 1);
      checks++;
      if (ir_valid !== 1'b0) begin
         errors++;
         $display("FAIL drop_no_valid: valid=%b, want 0", ir_valid);
      end
   endtask

   task automatic test_simultaneous_wrap();
      step(0, 1, 19'h0BEEF, 1, 12'hFFF, 1);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 12'hFFF || ir_valid !== 1'b0 || ir === 19'h0BEEF) begin
         errors++;
         $display("FAIL simul: req=%b addr=%h valid=%b ir=%h, want 1 fff 0 not 0beef", imem_req, imem_addr, ir_valid, ir);
      end
      step(0, 1, 19'h12345, 0, 0, 1);
      checks++;
      if (ir_valid !== 1'b1 || ir !== 19'h12345 || ir_pc !== 12'hFFF) begin
         errors++;
         $display("FAIL wrap_capture: valid=%b ir=%h ir_pc=%h, want 1 12345 fff", ir_valid, ir, ir_pc);
      end
      step(0, 0, 0, 0, 0, 1);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 12'h000) begin
         errors++;
         $display("FAIL wrap_addr: req=%b addr=%h, want 1 000", imem_req, imem_addr);
      end
   endtask

   task automatic test_reset_mid();
      step(0, 0, 0, 1, 12'h123, 0);
      step(1, 0, 0, 0, 0, 0);
      checks++;
      if (imem_req !== 1'b0 || ir_valid !== 1'b0 || imem_addr !== 12'h000 || ir !== 19'h0) begin
         errors++;
         $display("FAIL reset_mid: req=%b valid=%b addr=%h ir=%h, want 0 0 000 0", imem_req, ir_valid, imem_addr, ir);
      end
      step(0, 1, 19'h3C3C3, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      checks++;
      if (imem_req !== 1'b1 || ir_valid !== 1'b0 || imem_addr !== 12'h000) begin
         errors++;
         $display("FAIL stale_ack: req=%b valid=%b addr=%h, want 1 0 000", imem_req, ir_valid, imem_addr);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(99) == 0, $urandom_range(2) == 0, 19'($urandom),
              $urandom_range(7) == 0, 12'($urandom), $urandom_range(1) == 1);
         checks++;
         if (dut_v !== mod_v) begin
            errors++;
            $display("FAIL random%0d: req/addr/valid/ir/ir_pc dut=%h model=%h", i, dut_v, mod_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_backpressure();
      test_redirect_full();
      test_redirect_outstanding();
      test_simultaneous_wrap();
      test_reset_mid();
      checks++;
      if (dut_v !== mod_v) begin
         errors++;
         $display("FAIL directed_model: dut=%h model=%h", dut_v, mod_v);
      end
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
